intr_ctrl_prio: RTL



---
 rtl/intr_ctrl_pkg.sv | 19 +
 rtl/intr_ctrl_prio_arbiter.sv | 34 +++
 rtl/intr_ctrl_prio.sv | 126 ++++++++++++
 3 files changed

// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the prioritised interrupt controller.
// Holds the FSM encoding and default bus control codes.
package intr_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SEND    = 2'd2,
    S_SERVICE = 2'd3
  } state_t;

  localparam logic [4:0] TX_CODE_DEF   = 5'b01011;
  localparam logic [4:0] DONE_CODE_DEF = 5'b10100;

  function automatic int code_w(input int bus_w, input int id_w);
    return bus_w - id_w;
  endfunction

endpackage

// File: rtl/intr_ctrl_prio_arbiter.sv
// Combinational fixed/rotating priority arbiter.
// Rotation uses a doubled request vector masked below the start index.
module prio_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] pending,
  input  logic [ID_W-1:0]    last_id,
  input  logic               prio_mode,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id
);

  localparam int DW = 2 * NUM_SRC;

  logic [ID_W-1:0] start;
  logic [DW-1:0]   keep;
  logic [DW-1:0]   dbl;

  always_comb begin
    start = '0;
    if (prio_mode && last_id != ID_W'(NUM_SRC - 1))
      start = last_id + 1'b1;
    keep = ~((DW'(1) << start) - DW'(1));
    dbl = {pending, pending} & keep;
    grant_valid = |pending;
    grant_id = '0;
    // Scan high to low so the lowest set index is the last one written.
    for (int j = DW - 1; j >= 0; j--)
      if (dbl[j])
        grant_id = ID_W'(j % NUM_SRC);
  end

endmodule

// File: rtl/intr_ctrl_prio.sv
// Interrupt controller: arbitrates maskable sources and hands the
// winning ID to the processor over a shared bus via edge acks.
module intr_ctrl_prio
  import intr_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3,
  parameter int BUS_W   = 8,
  parameter logic [BUS_W-ID_W-1:0] TX_CODE   = TX_CODE_DEF,
  parameter logic [BUS_W-ID_W-1:0] DONE_CODE = DONE_CODE_DEF,
  parameter int TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] intr_rq,
  input  logic [NUM_SRC-1:0] intr_mask,
  input  logic               prio_mode,
  input  logic               intr_in,
  inout  wire  [BUS_W-1:0]   intr_bus,
  output logic               intr_out,
  output logic               bus_oe,
  output logic [ID_W-1:0]    active_id,
  output logic               err
);

  localparam int CW = code_w(BUS_W, ID_W);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t             state;
  logic [ID_W-1:0]    last_id;
  logic               intr_in_q;
  logic [TW-1:0]      timer;
  logic [BUS_W-1:0]   bus_q;
  logic               ack;
  logic               expired;
  logic [NUM_SRC-1:0] pending;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic [CW-1:0]      rx_code;
  logic [ID_W-1:0]    rx_id;

  assign ack      = intr_in_q & ~intr_in;
  assign expired  = (TIMEOUT != 0) && (timer == T_LAST);
  assign pending  = intr_rq & ~intr_mask;
  assign rx_code  = intr_bus[BUS_W-1:ID_W];
  assign rx_id    = intr_bus[ID_W-1:0];
  assign intr_bus = bus_oe ? bus_q : 'z;

  prio_arbiter #(
    .NUM_SRC(NUM_SRC),
    .ID_W   (ID_W)
  ) u_arb (
    .pending    (pending),
    .last_id    (last_id),
    .prio_mode  (prio_mode),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      intr_out  <= 1'b0;
      bus_oe    <= 1'b0;
      bus_q     <= '0;
      active_id <= '0;
      err       <= 1'b0;
      last_id   <= ID_W'(NUM_SRC - 1);
      intr_in_q <= 1'b1;
      timer     <= '0;
    end else begin
      intr_in_q <= intr_in;
      err       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (grant_valid) begin
            active_id <= grant_id;
            intr_out  <= 1'b1;
            timer     <= '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack) begin
            intr_out <= 1'b0;
            bus_oe   <= 1'b1;
            bus_q    <= {TX_CODE, active_id};
            timer    <= '0;
            state    <= S_SEND;
          end else if (expired) begin
            err      <= 1'b1;
            intr_out <= 1'b0;
            state    <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_SEND: begin
          if (ack) begin
            bus_oe <= 1'b0;
            state  <= S_SERVICE;
          end else if (expired) begin
            err    <= 1'b1;
            bus_oe <= 1'b0;
            state  <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_SERVICE: begin
          // Rotation only advances on a clean completion.
          if (ack) begin
            if (rx_code == DONE_CODE && rx_id == active_id)
              last_id <= active_id;
            else
              err <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
